// File: rtl/pc_fetch_unit_if.sv
// +----------------------------------------------------------------------------+
// | Module      : pc_fetch_unit_if                                             |
// | Description : Bundle of PC-mux, instruction-memory and decode handshakes.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

interface pc_fetch_unit_if;
  logic [31:0] pc_in;
  logic        pc_redirect;
  logic [31:0] pc_out;
  logic [31:0] pc_4;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        fetch_misalign;
`endif

  modport master (
    input  pc_in, pc_redirect, imem_gnt, imem_rvalid, imem_rdata, inst_ready,
`ifdef FETCH_MISALIGN_TRAP_EN
    output fetch_misalign,
`endif
    output pc_out, pc_4, imem_req, imem_addr, inst_valid, inst_data, inst_pc
  );

  modport slave (
    output pc_in, pc_redirect, imem_gnt, imem_rvalid, imem_rdata, inst_ready,
`ifdef FETCH_MISALIGN_TRAP_EN
    input  fetch_misalign,
`endif
    input  pc_out, pc_4, imem_req, imem_addr, inst_valid, inst_data, inst_pc
  );
endinterface

`default_nettype wire

// File: rtl/pc_fetch_unit.sv
// +----------------------------------------------------------------------------+
// | Module      : pc_fetch_unit                                                |
// | Description : PC register, single-outstanding IMEM fetch, 2-entry buffer.  |
// |               FETCH_MISALIGN_TRAP_EN enables the misaligned-PC trap.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  wire logic          clk,
  input  wire logic          rst,
  pc_fetch_unit_if.master    bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DROP = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_tag;
  logic [31:0] r_buf_pc   [2];
  logic [31:0] r_buf_data [2];
  logic        r_rd_ptr;
  logic        r_wr_ptr;
  logic [1:0]  r_count;

  logic        w_outstanding;
  logic        w_misalign;
  logic        w_req;
  logic        w_accept;
  logic        w_push;
  logic        w_pop;

  always_comb begin
    w_misalign    = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    w_misalign    = (r_state == S_REQ) && (r_pc[1:0] != 2'b00);
`endif
    w_outstanding = (r_state == S_WAIT) || (r_state == S_DROP);
    w_req         = (r_state == S_REQ) && !w_misalign &&
                    (({1'b0, r_count} + {2'b00, w_outstanding}) < 3'd2);
    w_accept      = w_req && bus.imem_gnt;
    // Redirect beats push and pop: flushed contents must not be refilled or consumed.
    w_push        = (r_state == S_WAIT) && bus.imem_rvalid && !bus.pc_redirect;
    w_pop         = (r_count != 2'd0) && bus.inst_ready && !bus.pc_redirect;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: w_state_nxt = S_REQ;
      S_REQ: begin
        if (w_accept) w_state_nxt = bus.pc_redirect ? S_DROP : S_WAIT;
      end
      // A response coinciding with a redirect is consumed and discarded here,
      // so there is nothing left to drop.
      S_WAIT: begin
        if (bus.imem_rvalid)      w_state_nxt = S_REQ;
        else if (bus.pc_redirect) w_state_nxt = S_DROP;
      end
      S_DROP: begin
        if (bus.imem_rvalid) w_state_nxt = S_REQ;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
      r_tag   <= 32'h0;
    end else begin
      r_state <= w_state_nxt;
      if (bus.pc_redirect || w_accept) r_pc <= bus.pc_in;
      if (w_accept) r_tag <= r_pc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_buf_pc[0]   <= 32'h0;
      r_buf_pc[1]   <= 32'h0;
      r_buf_data[0] <= 32'h0;
      r_buf_data[1] <= 32'h0;
      r_rd_ptr      <= 1'b0;
      r_wr_ptr      <= 1'b0;
      r_count       <= 2'd0;
    end else if (bus.pc_redirect) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_buf_pc[r_wr_ptr]   <= r_tag;
        r_buf_data[r_wr_ptr] <= bus.imem_rdata;
        r_wr_ptr             <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign bus.pc_out     = r_pc;
  assign bus.pc_4       = r_pc + 32'd4;
  assign bus.imem_req   = w_req;
`ifdef FETCH_MISALIGN_TRAP_EN
  assign bus.imem_addr      = r_pc;
  assign bus.fetch_misalign = w_misalign;
`else
  assign bus.imem_addr  = {r_pc[31:2], 2'b00};
`endif
  assign bus.inst_valid = (r_count != 2'd0);
  assign bus.inst_data  = r_buf_data[r_rd_ptr];
  assign bus.inst_pc    = r_buf_pc[r_rd_ptr];

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_pc_fetch_unit                                             |
// | Description : Self-checking bench for pc_fetch_unit against a queue model. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_pc_fetch_unit;

  localparam logic [31:0] C_RESET_PC = 32'h0000_0000;

  logic clk;
  logic rst;
  pc_fetch_unit_if u_if ();

  pc_fetch_unit #(.RESET_PC(C_RESET_PC)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: fetch PC, a queue of {pc,data}, and the in-flight request.
  logic [31:0] m_pc;
  logic [31:0] m_tag;
  bit          m_started;
  int          m_pend;        // 0 none, 1 live, 2 to be discarded
  logic [63:0] m_q[$];

  int          n_cmp;
  int          n_err;
  logic [31:0] seen_pc[$];
  logic        s_req, s_valid, s_mis;
  logic [31:0] s_pc_out, s_pc4, s_addr;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit m_misaligned();
`ifdef FETCH_MISALIGN_TRAP_EN
    return m_started && (m_pend == 0) && (m_pc[1:0] != 2'b00);
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit m_req();
    return m_started && (m_pend == 0) && (m_q.size() < 2) && !m_misaligned();
  endfunction

  task automatic model_reset();
    m_pc      = C_RESET_PC;
    m_tag     = 32'h0;
    m_started = 1'b0;
    m_pend    = 0;
    m_q.delete();
  endtask

  task automatic model_update(input bit rd, input logic [31:0] pi, input bit g,
                              input bit rv, input logic [31:0] dat, input bit rdy);
    bit acc, do_pop, do_push;
    acc     = m_req() && g;
    do_pop  = (m_q.size() != 0) && rdy && !rd;
    do_push = 1'b0;
    if (m_pend != 0 && rv) begin
      do_push = (m_pend == 1) && !rd;
      m_pend  = 0;
    end
    if (do_pop) void'(m_q.pop_front());
    if (do_push) m_q.push_back({m_tag, dat});
    if (acc) begin
      m_tag  = m_pc;
      m_pend = rd ? 2 : 1;
      m_pc   = pi;
    end
    if (rd) begin
      m_pc = pi;
      m_q.delete();
      if (m_pend == 1) m_pend = 2;
    end
    m_started = 1'b1;
  endtask

  task automatic compare_outputs(input bit in_reset);
    logic [31:0] exp_addr;
`ifdef FETCH_MISALIGN_TRAP_EN
    exp_addr = m_pc;
    check_value("misalign", {31'd0, u_if.fetch_misalign}, {31'd0, m_misaligned()});
`else
    exp_addr = m_pc & 32'hFFFF_FFFC;
`endif
    check_value("pc_out", u_if.pc_out, m_pc);
    check_value("pc_4", u_if.pc_4, m_pc + 32'd4);
    check_value("imem_req", {31'd0, u_if.imem_req}, {31'd0, m_req()});
    check_value("imem_addr", u_if.imem_addr, exp_addr);
    check_value("inst_valid", {31'd0, u_if.inst_valid}, {31'd0, m_q.size() != 0});
    if (m_q.size() != 0) begin
      check_value("inst_pc", u_if.inst_pc, m_q[0][63:32]);
      check_value("inst_data", u_if.inst_data, m_q[0][31:0]);
    end
    if (in_reset) begin
      check_value("rst_inst_pc", u_if.inst_pc, 32'h0);
      check_value("rst_inst_data", u_if.inst_data, 32'h0);
    end
  endtask

  task automatic step(input bit r, input bit rd, input logic [31:0] pi, input bit g,
                      input bit rv, input logic [31:0] dat, input bit rdy);
    @(negedge clk);
    rst               = r;
    u_if.pc_redirect  = rd;
    u_if.pc_in        = pi;
    u_if.imem_gnt     = g;
    u_if.imem_rvalid  = rv;
    u_if.imem_rdata   = dat;
    u_if.inst_ready   = rdy;
    if (r) model_reset();
    #1;
    compare_outputs(r);
    s_req    = u_if.imem_req;
    s_valid  = u_if.inst_valid;
    s_pc_out = u_if.pc_out;
    s_pc4    = u_if.pc_4;
    s_addr   = u_if.imem_addr;
`ifdef FETCH_MISALIGN_TRAP_EN
    s_mis    = u_if.fetch_misalign;
`else
    s_mis    = 1'b0;
`endif
    if (!r && u_if.inst_valid && rdy && !rd) seen_pc.push_back(u_if.inst_pc);
    @(posedge clk);
    if (!r) model_update(rd, pi, g, rv, dat, rdy);
  endtask

  task automatic run(input int n, input bit g, input bit rv, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, m_pc + 32'd4, g, rv, $urandom, rdy);
  endtask

  task automatic redirect_to(input logic [31:0] a);
    step(1'b0, 1'b1, a, 1'b0, 1'b0, $urandom, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic check_seen(input string tag, input int idx, input logic [31:0] exp);
    logic [31:0] got;
    got = (idx < seen_pc.size()) ? seen_pc[idx] : 32'hDEAD_BEEF;
    check_value(tag, got, exp);
  endtask

  initial begin
    bit          rd;
    logic [31:0] tgt;
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    u_if.pc_in = 32'h0;       u_if.pc_redirect = 1'b0;
    u_if.imem_gnt = 1'b0;     u_if.imem_rvalid = 1'b0;
    u_if.imem_rdata = 32'h0;  u_if.inst_ready = 1'b0;
    model_reset();

    // Streaming with single-cycle memory
    do_reset();
    seen_pc.delete();
    run(9, 1'b1, 1'b1, 1'b1);
    check_seen("seq0", 0, 32'h0);
    check_seen("seq1", 1, 32'h4);
    check_seen("seq2", 2, 32'h8);

    // Back-pressure fills the buffer, then drain
    do_reset();
    run(12, 1'b1, 1'b1, 1'b0);
    check_value("full_valid", {31'd0, s_valid}, 32'd1);
    check_value("full_req", {31'd0, s_req}, 32'd0);
    seen_pc.delete();
    run(4, 1'b0, 1'b0, 1'b1);
    check_seen("drain0", 0, 32'h0);
    check_seen("drain1", 1, 32'h4);
    check_value("drain_cnt", seen_pc.size(), 32'd2);
    check_value("drain_empty", {31'd0, s_valid}, 32'd0);

    // Redirect while waiting drops the stale response
    do_reset();
    run(1, 1'b0, 1'b0, 1'b0);
    run(1, 1'b1, 1'b0, 1'b0);
    redirect_to(32'h100);
    step(1'b0, 1'b0, m_pc + 32'd4, 1'b0, 1'b1, $urandom, 1'b0);
    run(1, 1'b0, 1'b0, 1'b0);
    check_value("drop_valid", {31'd0, s_valid}, 32'd0);
    check_value("drop_pc", s_pc_out, 32'h100);
    seen_pc.delete();
    run(6, 1'b1, 1'b1, 1'b1);
    check_seen("drop_first", 0, 32'h100);

    // PC wrap
    redirect_to(32'hFFFF_FFFC);
    run(1, 1'b0, 1'b0, 1'b0);
    check_value("wrap_pc4", s_pc4, 32'h0);
    run(1, 1'b1, 1'b0, 1'b0);
    run(1, 1'b0, 1'b1, 1'b0);
    run(1, 1'b0, 1'b0, 1'b0);
    check_value("wrap_addr", s_addr, 32'h0);

    // Reset during WAIT, late response ignored
    do_reset();
    run(1, 1'b0, 1'b0, 1'b0);
    run(1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    check_value("midrst_pc", s_pc_out, C_RESET_PC);
    check_value("midrst_req", {31'd0, s_req}, 32'd0);
    step(1'b0, 1'b0, m_pc + 32'd4, 1'b0, 1'b1, $urandom, 1'b0);
    run(2, 1'b0, 1'b1, 1'b0);
    check_value("midrst_valid", {31'd0, s_valid}, 32'd0);

`ifdef FETCH_MISALIGN_TRAP_EN
    redirect_to(32'h102);
    run(1, 1'b1, 1'b0, 1'b0);
    check_value("mis_set", {31'd0, s_mis}, 32'd1);
    check_value("mis_noreq", {31'd0, s_req}, 32'd0);
    redirect_to(32'h104);
    run(1, 1'b0, 1'b0, 1'b0);
    check_value("mis_clr", {31'd0, s_mis}, 32'd0);
    check_value("mis_req", {31'd0, s_req}, 32'd1);
`endif

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        step(1'b1, 1'b0, $urandom, 1'b0, $urandom_range(0, 1), $urandom, 1'b0);
      end else begin
        rd = ($urandom_range(0, 19) == 0);
        case ($urandom_range(0, 7))
          0:       tgt = $urandom;
          1:       tgt = 32'hFFFF_FFFC;
          default: tgt = $urandom & 32'hFFFF_FFFC;
        endcase
        step(1'b0, rd, rd ? tgt : m_pc + 32'd4, $urandom_range(0, 9) < 6,
             $urandom_range(0, 1), $urandom, $urandom_range(0, 9) < 6);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 RST  input  1  reset, asynchronous and active-high.
REQ-004 PC_IN  input  32  next-PC from PC selection mux.
REQ-005 PC_Redirect  input  1  high when PC selection is non-sequential (branch/JAL/JALR taken).
REQ-006 PC_Out  output  32  current fetch PC (register).
REQ-007 PC_4  output  32  PC_Out + 4, combinational, fed back to PC selection mux.
REQ-008 IMEM_Req  output  1  instruction memory request valid.
REQ-009 IMEM_Addr  output  32  request address, equals PC_Out.
REQ-010 IMEM_Gnt  input  1  memory accepts request this cycle.
REQ-011 IMEM_RValid  input  1  read data valid.
REQ-012 IMEM_RData  input  32  read instruction word.
REQ-013 INST_Valid  output  1  buffered instruction available to decode.
REQ-014 INST_Ready  input  1  decode consumes instruction.
REQ-015 INST_Data / INST_PC  output  32 each  head-of-buffer instruction and its PC.
REQ-016 FETCH_Misalign  output  1  misaligned-PC flag (present only with macro, REQ-033).

Function
REQ-017 Request accepted when IMEM_Req && IMEM_Gnt; response returns on a later cycle with IMEM_RValid; at most one request outstanding.
REQ-018 FSM states: IDLE, REQ, WAIT, DROP.
REQ-019 IDLE -> REQ one cycle after reset release; IMEM_Req low in IDLE.
REQ-020 REQ: IMEM_Req high iff (buffer count + outstanding) < 2; on accept PC_Out <= PC_IN, tag request with old PC_Out, -> WAIT.
REQ-021 WAIT: on IMEM_RValid push {tag PC, IMEM_RData} into buffer, -> REQ; IMEM_Req low.
REQ-022 Buffer: 2-entry FIFO, head drives INST_Data/INST_PC; INST_Valid = count != 0; pop on INST_Valid && INST_Ready; push and pop same cycle keep count unchanged.
REQ-023 Redirect (PC_Redirect high), any state: PC_Out <= PC_IN next cycle, buffer flushed (count 0, INST_Valid low next cycle), no pop counted.
REQ-024 Redirect in WAIT, or in REQ coincident with accept: -> DROP; the outstanding response is discarded on arrival, then -> REQ.
REQ-025 Redirect in IDLE/REQ without accept: -> REQ.
REQ-026 Redirect has priority over grant-driven PC update and over buffer push.
REQ-027 PC_4 wraps modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
REQ-028 IMEM_RValid outside WAIT/DROP ignored.
REQ-029 Throughput: one instruction per two cycles with single-cycle memory (REQ/WAIT alternation).

Reset
REQ-030 On RST: PC_Out = RESET_PC, state IDLE, buffer empty, outstanding cleared, IMEM_Req = 0, INST_Valid = 0, INST_Data = 0, INST_PC = 0, FETCH_Misalign = 0.
REQ-031 RST asserted mid-WAIT: response arriving after release is ignored (state IDLE).

Configuration
REQ-032 Macro FETCH_MISALIGN_TRAP_EN controls misalignment checking.
REQ-033 Defined: if PC_Out[1:0] != 0 in REQ, IMEM_Req held low, FETCH_Misalign high until redirect or reset. Undefined: port absent, IMEM_Addr = {PC_Out[31:2],2'b00}, no check.

Verification
REQ-034 Reset release, Gnt=1, RValid one cycle after accept, Ready=1 -> INST_PC sequence 0,4,8 with matching data.
REQ-035 Ready=0, memory always responds -> exactly 2 instructions buffered, IMEM_Req low thereafter; Ready=1 drains in order.
REQ-036 Redirect to 32'h100 while WAIT -> stale response dropped, buffer empty, next INST_PC = 32'h100.
REQ-037 PC_Out = 32'hFFFF_FFFC -> PC_4 = 0, next fetch address 0.
REQ-038 With FETCH_MISALIGN_TRAP_EN, redirect to 32'h102 -> FETCH_Misalign = 1, no request; redirect to 32'h104 clears flag.
REQ-039 RST pulse during WAIT -> all outputs at reset values, late RValid produces no INST_Valid.
